// File: rtl/bus_pkg.sv
`default_nettype none
// ============================================================
// Module : bus_pkg
// Desc   : Shared response and FSM state encodings for bus_slave
// Rev    : 1.0 - initial release
// ============================================================
package bus_pkg;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b01
    } resp_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        BEAT = 2'b10
    } state_e;

    // Wait-state counter is 4 bits wide.
    localparam int c_max_wait = 15;

endpackage
`default_nettype wire

// File: rtl/bus_slave_mem.sv
`default_nettype none
// ============================================================
// Module : bus_slave_mem
// Desc   : Word storage with write port, registered read port, reset clear
// Rev    : 1.0 - initial release
// ============================================================
module bus_slave_mem #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_wr_en,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_rd_en,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    output logic [DATA_WIDTH-1:0] o_rd_data
);

    localparam int                c_idx_w = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] c_depth = (ADDR_WIDTH+1)'(MEM_DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic                  w_wr_ok;
    logic                  w_rd_ok;

    // Range checks use the full address so out-of-range accesses never alias.
    assign w_wr_ok = i_wr_en && ({1'b0, i_wr_addr} < c_depth);
    assign w_rd_ok = i_rd_en && ({1'b0, i_rd_addr} < c_depth);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_rd_data <= '0;
        end else begin
            if (w_wr_ok) begin
                r_mem[i_wr_addr[c_idx_w-1:0]] <= i_wr_data;
            end
            r_rd_data <= w_rd_ok ? r_mem[i_rd_addr[c_idx_w-1:0]] : '0;
        end
    end

    assign o_rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/bus_slave.sv
`default_nettype none
// ============================================================
// Module : bus_slave
// Desc   : Burst-capable memory slave with configurable wait states
// Rev    : 1.0 - initial release
// ============================================================
module bus_slave #(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_DEPTH   = 64,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid,
    output logic                  ready,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [1:0]            resp,
    input  logic [3:0]            burst_len,
    output logic                  busy
);

    import bus_pkg::*;

    localparam int                  c_wait_cfg = (WAIT_CYCLES > c_max_wait) ? c_max_wait : WAIT_CYCLES;
    localparam logic [3:0]          c_wait     = 4'(c_wait_cfg);
    localparam logic [ADDR_WIDTH:0] c_depth    = (ADDR_WIDTH+1)'(MEM_DEPTH);

    state_e                r_state;
    state_e                w_state_next;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH-1:0] w_addr_next;
    logic                  r_wr;
    logic                  w_wr_next;
    logic [3:0]            r_beat_cnt;
    logic [3:0]            w_beat_cnt_next;
    logic [3:0]            r_wait_cnt;
    logic [3:0]            w_wait_cnt_next;
    logic                  w_hs;
    logic                  w_in_range;
    logic                  w_mem_rd_en;
    logic [DATA_WIDTH-1:0] w_mem_rdata;

    assign w_hs       = (r_state == BEAT) && valid;
    assign w_in_range = ({1'b0, r_addr} < c_depth);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_addr     <= '0;
            r_wr       <= 1'b0;
            r_beat_cnt <= '0;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_next;
            r_addr     <= w_addr_next;
            r_wr       <= w_wr_next;
            r_beat_cnt <= w_beat_cnt_next;
            r_wait_cnt <= w_wait_cnt_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_addr_next     = r_addr;
        w_wr_next       = r_wr;
        w_beat_cnt_next = r_beat_cnt;
        w_wait_cnt_next = r_wait_cnt;
        case (r_state)
            IDLE: begin
                if (valid) begin
                    w_addr_next     = addr;
                    w_wr_next       = wr_en;
                    w_beat_cnt_next = burst_len;
                    w_wait_cnt_next = c_wait;
                    w_state_next    = (c_wait != 4'd0) ? WAIT : BEAT;
                end
            end
            WAIT: begin
                if (!valid) begin
                    w_state_next    = IDLE;
                    w_beat_cnt_next = '0;
                    w_wait_cnt_next = '0;
                end else begin
                    w_wait_cnt_next = r_wait_cnt - 4'd1;
                    if (r_wait_cnt <= 4'd1) begin
                        w_state_next = BEAT;
                    end
                end
            end
            BEAT: begin
                if (!valid || (r_beat_cnt == 4'd0)) begin
                    w_state_next    = IDLE;
                    w_beat_cnt_next = '0;
                    w_wait_cnt_next = '0;
                end else begin
                    w_beat_cnt_next = r_beat_cnt - 4'd1;
                    w_addr_next     = r_addr + 1'b1;
                    w_wait_cnt_next = c_wait;
                    w_state_next    = (c_wait != 4'd0) ? WAIT : BEAT;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Prefetch the next beat's word so it is registered by the time BEAT is entered.
    assign w_mem_rd_en = (w_state_next == BEAT) && !w_wr_next;

    bus_slave_mem #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH)
    ) u_mem (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_hs && r_wr && w_in_range),
        .i_wr_addr (r_addr),
        .i_wr_data (wdata),
        .i_rd_en   (w_mem_rd_en),
        .i_rd_addr (w_addr_next),
        .o_rd_data (w_mem_rdata)
    );

    assign ready = w_hs;
    assign busy  = (r_state != IDLE);
    assign resp  = (w_hs && !w_in_range) ? RESP_SLVERR : RESP_OKAY;
    assign rdata = (w_hs && !r_wr && w_in_range) ? w_mem_rdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_bus_slave.sv
`default_nettype none
// ============================================================
// Module : tb_bus_slave
// Desc   : Self-checking bench for bus_slave (WAIT_CYCLES 0 and 1 instances)
// Rev    : 1.0 - initial release
// ============================================================
module tb_bus_slave;

    typedef struct {
        int          d;          // instance index == its WAIT_CYCLES
        bit          wr;
        logic [7:0]  a0;
        logic [3:0]  len;
        logic [31:0] d0;         // beat k carries d0 + k
        logic [15:0] err_mask;   // bit k set: beat k expects SLVERR
        logic [31:0] exp_rd0;
        bit          chk_rd0;
        int          abort_after;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        valid     [2];
    logic        wr_en     [2];
    logic [7:0]  addr      [2];
    logic [31:0] wdata     [2];
    logic [3:0]  burst_len [2];
    logic        ready     [2];
    logic        busy      [2];
    logic [31:0] rdata     [2];
    logic [1:0]  resp      [2];

    logic [31:0] model_mem [2][64];
    int          errors;
    int          checks;
    vec_t        vecs [13];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        bus_slave #(
            .ADDR_WIDTH  (8),
            .DATA_WIDTH  (32),
            .MEM_DEPTH   (64),
            .WAIT_CYCLES (g)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .valid     (valid[g]),
            .ready     (ready[g]),
            .wr_en     (wr_en[g]),
            .addr      (addr[g]),
            .wdata     (wdata[g]),
            .rdata     (rdata[g]),
            .resp      (resp[g]),
            .burst_len (burst_len[g]),
            .busy      (busy[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 64; j++)
                model_mem[i][j] = '0;
    endtask

    // Beat k of a burst started in cycle 0 completes in cycle (k+1)*(W+1).
    task automatic run_burst(input vec_t v, input bit chk_mask);
        int          p, stop, done;
        bit          aborting, timed_out;
        logic [7:0]  ba;
        logic        err;
        logic [31:0] exp_rd;
        p         = v.d + 1;
        stop      = (v.abort_after >= 0 && v.abort_after < int'(v.len)) ? v.abort_after : int'(v.len);
        aborting  = (stop < int'(v.len));
        done      = 0;
        timed_out = 1'b1;
        @(posedge clk); #1;
        valid[v.d] = 1'b1; wr_en[v.d] = v.wr; addr[v.d] = v.a0;
        burst_len[v.d] = v.len; wdata[v.d] = v.d0;
        @(negedge clk);
        check("start_ready", ready[v.d], 0);
        check("start_busy", busy[v.d], 0);
        for (int c = 1; c < 200; c++) begin
            @(posedge clk); #1;
            // Address, direction and length are don't-care once the burst is latched.
            addr[v.d]      = 8'($urandom);
            wr_en[v.d]     = 1'($urandom);
            burst_len[v.d] = 4'($urandom);
            wdata[v.d]     = v.d0 + 32'(done);
            if (done > stop) valid[v.d] = 1'b0;
            @(negedge clk);
            if (!valid[v.d]) begin
                check("end_ready", ready[v.d], 0);
                check("end_resp", resp[v.d], 0);
                check("end_rdata", rdata[v.d], 0);
                check("end_busy", busy[v.d], aborting ? 1 : 0);
                if (aborting) begin
                    @(posedge clk); #1;
                    @(negedge clk);
                    check("abort_busy", busy[v.d], 0);
                    check("abort_ready", ready[v.d], 0);
                end
                timed_out = 1'b0;
                break;
            end
            check("busy", busy[v.d], 1);
            if (c % p == 0) begin
                ba  = v.a0 + 8'(done);
                err = (ba >= 8'd64);
                check("beat_ready", ready[v.d], 1);
                check("beat_resp", resp[v.d], err ? 2'b01 : 2'b00);
                if (chk_mask) check("beat_resp_tbl", resp[v.d], {1'b0, v.err_mask[done]});
                if (v.wr) begin
                    check("wr_rdata", rdata[v.d], 0);
                    if (!err) model_mem[v.d][int'(ba)] = v.d0 + 32'(done);
                end else begin
                    exp_rd = err ? 32'h0 : model_mem[v.d][int'(ba[5:0])];
                    check("rd_rdata", rdata[v.d], exp_rd);
                    if (v.chk_rd0 && done == 0) check("rd_rdata_tbl", rdata[v.d], v.exp_rd0);
                end
                done++;
            end else begin
                check("wait_ready", ready[v.d], 0);
                check("wait_resp", resp[v.d], 0);
                check("wait_rdata", rdata[v.d], 0);
            end
        end
        if (timed_out) check("burst_timeout", 1, 0);
        valid[v.d] = 1'b0;
    endtask

    initial begin
        vec_t rv;
        errors = 0;
        checks = 0;
        clear_model();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            valid[i] = 1'b0; wr_en[i] = 1'b0; addr[i] = '0;
            wdata[i] = '0; burst_len[i] = '0;
        end

        //        d  wr  a0     len   d0            mask      exp_rd0       chk abort
        vecs[0]  = '{1, 1, 8'h05, 4'd0, 32'hDEADBEEF, 16'h0000, 32'h0,        0, -1};
        vecs[1]  = '{1, 0, 8'h05, 4'd0, 32'h0,        16'h0000, 32'hDEADBEEF, 1, -1};
        vecs[2]  = '{0, 1, 8'h10, 4'd3, 32'h1,        16'h0000, 32'h0,        0, -1};
        vecs[3]  = '{0, 0, 8'h10, 4'd3, 32'h0,        16'h0000, 32'h1,        1, -1};
        vecs[4]  = '{1, 0, 8'h40, 4'd0, 32'h0,        16'h0001, 32'h0,        1, -1};
        vecs[5]  = '{1, 1, 8'h45, 4'd0, 32'h12345678, 16'h0001, 32'h0,        0, -1};
        vecs[6]  = '{1, 0, 8'h05, 4'd0, 32'h0,        16'h0000, 32'hDEADBEEF, 1, -1};
        vecs[7]  = '{1, 1, 8'h3E, 4'd3, 32'hA0,       16'h000C, 32'h0,        0, -1};
        vecs[8]  = '{1, 0, 8'h3E, 4'd3, 32'h0,        16'h000C, 32'hA0,       1, -1};
        vecs[9]  = '{0, 1, 8'hFE, 4'd2, 32'h77,       16'h0003, 32'h0,        0, -1};
        vecs[10] = '{0, 0, 8'h00, 4'd0, 32'h0,        16'h0000, 32'h79,       1, -1};
        vecs[11] = '{1, 1, 8'h20, 4'd3, 32'hB0,       16'h0000, 32'h0,        0,  1};
        vecs[12] = '{1, 0, 8'h20, 4'd3, 32'h0,        16'h0000, 32'hB0,       1, -1};

        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check("rst_ready", ready[i], 0);
            check("rst_busy", busy[i], 0);
            check("rst_rdata", rdata[i], 0);
            check("rst_resp", resp[i], 0);
        end
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 13; i++) run_burst(vecs[i], 1'b1);

        for (int n = 0; n < 60; n++) begin
            rv.d           = int'($urandom_range(0, 1));
            rv.wr          = 1'($urandom_range(0, 1));
            rv.a0          = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                                         : 8'($urandom_range(0, 70));
            rv.len         = 4'($urandom_range(0, 15));
            rv.d0          = $urandom;
            rv.err_mask    = '0;
            rv.exp_rd0     = '0;
            rv.chk_rd0     = 1'b0;
            rv.abort_after = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 15)) : -1;
            run_burst(rv, 1'b0);
        end

        // Reset pulsed during beat 2 of a WAIT_CYCLES=1 write burst.
        @(posedge clk); #1;
        valid[1] = 1'b1; wr_en[1] = 1'b1; addr[1] = 8'h00; burst_len[1] = 4'd3; wdata[1] = 32'h55;
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk); #1;
            wdata[1] = 32'h55 + 32'(c / 2);
        end
        @(negedge clk);
        check("midrst_pre_ready", ready[1], 1);
        #1 rst = 1'b1;
        #1;
        check("midrst_ready", ready[1], 0);
        check("midrst_busy", busy[1], 0);
        check("midrst_resp", resp[1], 0);
        check("midrst_rdata", rdata[1], 0);
        @(posedge clk); #1;
        rst = 1'b0;
        valid[1] = 1'b0;
        clear_model();

        rv = '{1, 0, 8'h00, 4'd15, 32'h0, 16'h0000, 32'h0, 1, -1};
        run_burst(rv, 1'b1);
        rv = '{1, 0, 8'h38, 4'd15, 32'h0, 16'hFF00, 32'h0, 1, -1};
        run_burst(rv, 1'b1);
        rv = '{0, 0, 8'h00, 4'd15, 32'h0, 16'h0000, 32'h0, 1, -1};
        run_burst(rv, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
